prime_frame_stats: RTL and testbench
====================================

# prime_frame_stats

Downstream consumer of the 3-bit prime detector stage. Accepts a stream of detector samples (the 3-bit input value A,B,C plus the detector result F) over a valid/ready handshake and groups them into fixed-length frames. Per frame it reports the prime count, the longest run of consecutive primes, and the last prime value. It also flags any sample where F disagrees with the true primality of {A,B,C}. The report is presented on an output valid/ready handshake and held until consumed.

## Interface
- FRAME_LEN, 8, accepted samples per frame; legal range 1 .. 2^CNT_W-1
- CNT_W, 4, width of prime_cnt and max_run

- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  sample present on A,B,C,F
- in_ready  output  1  block can accept a sample
- A  input  1  value bit 2 (MSB)
- B  input  1  value bit 1
- C  input  1  value bit 0 (LSB)
- F  input  1  prime flag from the detector stage
- out_valid  output  1  frame report present
- out_ready  input  1  consumer takes report
- prime_cnt  output  CNT_W  samples in frame with F=1
- max_run  output  CNT_W  longest run of consecutive accepted samples with F=1
- last_prime  output  3  {A,B,C} of last accepted sample with F=1; 0 if none
- mismatch  output  1  some sample in frame had F != prime({A,B,C})

## Operation
- Reference primality: prime({A,B,C}) is 1 for values 2, 3, 5, 7 and 0 for 0, 1, 4, 6.
- Accept event: in_valid & in_ready.
- FSM has two states, ACCUM (reset state) and REPORT.
- ACCUM:
  - in_ready=1.
  - On each accept:
    - sample index increments.
    - If F=1: prime accumulator +1, cur_run +1, last-prime register <= {A,B,C}.
    - If F=0: cur_run <= 0.
    - Run max accumulator <= max(run max, updated cur_run).
    - Mismatch accumulator ORs in (F ^ prime({A,B,C})).
  - On the accept of sample FRAME_LEN (index FRAME_LEN-1):
    - Output registers load the accumulator values including that sample.
    - out_valid <= 1; state -> REPORT.
- REPORT:
  - in_ready=0; in_valid ignored.
  - All output fields held stable.
  - On out_valid & out_ready: out_valid <= 0; accumulators, cur_run and sample index clear; state -> ACCUM.
- Statistics use F as received, including mismatching samples. Only mismatch reflects the reference check.
- Idle cycles (in_valid=0) do not break a prime run. Runs are over accepted samples only.
- Counters never exceed FRAME_LEN, so they never wrap for legal parameters. No saturation logic is needed.
- FRAME_LEN=1: every accept produces a report.

## Timing
- Reset values (output registers and state, applied in the rst cycle):
  - out_valid=0, prime_cnt=0, max_run=0, last_prime=0, mismatch=0.
  - State=ACCUM; all accumulators 0.
- in_ready:
  - Decoded from state only, with no combinational path from in_valid or out_ready.
  - Forced to 0 while rst=1.
- Report latency: final sample accepted in cycle t -> out_valid=1 with valid fields in cycle t+1.
- Turnaround: report taken in cycle u -> in_ready=1 in cycle u+1.
- Minimum frame period is FRAME_LEN+1 cycles.
- Reset mid-frame or mid-REPORT drops the partial frame and any pending report. The next accepted sample is index 0 of a new frame.
- Output fields change only on the cycle out_valid rises. They are don't-care-stable (held) after the report is taken, until the next report.

## Test plan
- Reset, then values 0..7 once per cycle with correct F and out_ready=1:
  - prime_cnt=4, max_run=2, last_prime=7, mismatch=0.
  - out_valid high exactly one cycle after the 8th accept.
- Same sweep with F forced to 1 for value 4:
  - prime_cnt=5, max_run=4, last_prime=7, mismatch=1.
  - Next clean frame reports mismatch=0.
- Backpressure: hold out_ready=0 for 5 cycles after a report while driving in_valid=1:
  - Fields stay constant, in_ready=0, no samples consumed.
  - After the handshake, in_ready=1 the next cycle.
- Random in_valid bubbles inserted into the 0..7 sweep give results identical to scenario 1. Bubbles between 2 and 3 still give max_run=2.
- Assert rst after 5 accepts, then send eight samples of value 7 with F=1:
  - prime_cnt=8, max_run=8, last_prime=7, mismatch=0.
- Frame of eight value-0 samples with F=0:
  - prime_cnt=0, max_run=0, last_prime=0, mismatch=0.

Source files
------------

// File: rtl/prime_frame_stats_if.sv
// rtl/prime_frame_stats_if.sv - sample input and frame report handshakes for prime_frame_stats
interface prime_frame_stats_if #(
    parameter int CNT_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic             A;
    logic             B;
    logic             C;
    logic             F;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] prime_cnt;
    logic [CNT_W-1:0] max_run;
    logic [2:0]       last_prime;
    logic             mismatch;

    modport master (
        output in_valid, A, B, C, F, out_ready,
        input  in_ready, out_valid, prime_cnt, max_run, last_prime, mismatch
    );

    modport slave (
        input  in_valid, A, B, C, F, out_ready,
        output in_ready, out_valid, prime_cnt, max_run, last_prime, mismatch
    );
endinterface

// File: rtl/prime_frame_stats.sv
// rtl/prime_frame_stats.sv - per-frame prime statistics over 3-bit detector samples
module prime_frame_stats #(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    prime_frame_stats_if.slave   bus
);
    localparam logic [0:0] ACCUM  = 1'b0;
    localparam logic [0:0] REPORT = 1'b1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    function automatic logic is_prime(input logic [2:0] v);
        case (v)
            3'd2, 3'd3, 3'd5, 3'd7: is_prime = 1'b1;
            default:                is_prime = 1'b0;
        endcase
    endfunction

    logic [0:0]       state;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] acc_cnt, cur_run, run_max;
    logic [2:0]       acc_last;
    logic             acc_mis;

    logic             out_valid_q, mismatch_q;
    logic [CNT_W-1:0] prime_cnt_q, max_run_q;
    logic [2:0]       last_prime_q;

    logic             ready, accept;
    logic [2:0]       sample;
    logic [CNT_W-1:0] nxt_cnt, nxt_run, nxt_max;
    logic [2:0]       nxt_last;
    logic             nxt_mis;

    // ready depends on state and reset only, never on the handshake inputs
    assign ready  = (state == ACCUM) & ~rst;
    assign accept = bus.in_valid & ready;
    assign sample = {bus.A, bus.B, bus.C};

    always_comb begin
        nxt_cnt  = acc_cnt + CNT_W'(bus.F);
        nxt_run  = bus.F ? cur_run + CNT_W'(1) : '0;
        nxt_max  = (nxt_run > run_max) ? nxt_run : run_max;
        nxt_last = bus.F ? sample : acc_last;
        nxt_mis  = acc_mis | (bus.F ^ is_prime(sample));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ACCUM;
            idx          <= '0;
            acc_cnt      <= '0;
            cur_run      <= '0;
            run_max      <= '0;
            acc_last     <= '0;
            acc_mis      <= 1'b0;
            out_valid_q  <= 1'b0;
            prime_cnt_q  <= '0;
            max_run_q    <= '0;
            last_prime_q <= '0;
            mismatch_q   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        idx      <= idx + CNT_W'(1);
                        acc_cnt  <= nxt_cnt;
                        cur_run  <= nxt_run;
                        run_max  <= nxt_max;
                        acc_last <= nxt_last;
                        acc_mis  <= nxt_mis;
                        if (idx == LAST_IDX) begin
                            prime_cnt_q  <= nxt_cnt;
                            max_run_q    <= nxt_max;
                            last_prime_q <= nxt_last;
                            mismatch_q   <= nxt_mis;
                            out_valid_q  <= 1'b1;
                            state        <= REPORT;
                        end
                    end
                end
                default: begin
                    // accumulators clear only once the report is taken
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        idx         <= '0;
                        acc_cnt     <= '0;
                        cur_run     <= '0;
                        run_max     <= '0;
                        acc_last    <= '0;
                        acc_mis     <= 1'b0;
                        state       <= ACCUM;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready   = ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.prime_cnt  = prime_cnt_q;
    assign bus.max_run    = max_run_q;
    assign bus.last_prime = last_prime_q;
    assign bus.mismatch   = mismatch_q;
endmodule

// File: tb/tb_prime_frame_stats.sv
// tb/tb_prime_frame_stats.sv - scoreboard bench for prime_frame_stats
module tb_prime_frame_stats;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    prime_frame_stats_if #(.CNT_W(4)) bus ();

    prime_frame_stats #(.FRAME_LEN(8), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [3:0] cnt;
        logic [3:0] run;
        logic [2:0] last;
        logic       mis;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    logic [7:0] prime_tab = 8'b1010_1100;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // monitor: a report is taken at the next rising edge when valid and ready are both high
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_report", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("prime_cnt", int'(bus.prime_cnt), int'(e.cnt));
                    check("max_run", int'(bus.max_run), int'(e.run));
                    check("last_prime", int'(bus.last_prime), int'(e.last));
                    check("mismatch", int'(bus.mismatch), int'(e.mis));
                end
            end
        end
    end

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int v, input logic f);
        logic rdy;
        int   guard;
        guard = 0;
        bus.in_valid = 1'b1;
        {bus.A, bus.B, bus.C} = 3'(v);
        bus.F = f;
        forever begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            guard++;
            if (guard > 50) begin
                check("send_timeout", 0, 1);
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (bus.out_valid && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (bus.out_valid) check("drain_timeout", 0, 1);
    endtask

    task automatic sweep(input bit force4, input bit bubbles);
        logic f;
        for (int v = 0; v < 8; v++) begin
            f = prime_tab[v] | (force4 && v == 4);
            if (bubbles) idle(int'($urandom_range(0, 2)));
            if (bubbles && v == 3) idle(3);
            send(v, f);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.A = 1'b0;
        bus.B = 1'b0;
        bus.C = 1'b0;
        bus.F = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", int'(bus.in_ready), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_prime_cnt", int'(bus.prime_cnt), 0);
        check("rst_max_run", int'(bus.max_run), 0);
        check("rst_last_prime", int'(bus.last_prime), 0);
        check("rst_mismatch", int'(bus.mismatch), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // clean sweep 0..7
        sb.push_back('{4'd4, 4'd2, 3'd7, 1'b0});
        sweep(1'b0, 1'b0);
        check("report_latency", int'(bus.out_valid), 1);

        // detector wrongly flags 4 as prime
        sb.push_back('{4'd5, 4'd4, 3'd7, 1'b1});
        sweep(1'b1, 1'b0);
        drain();

        // clean frame held under backpressure; stall samples must not be consumed
        bus.out_ready = 1'b0;
        sb.push_back('{4'd4, 4'd2, 3'd7, 1'b0});
        sweep(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            {bus.A, bus.B, bus.C} = 3'd4;
            bus.F = 1'b1;
            @(negedge clk);
            check("bp_in_ready", int'(bus.in_ready), 0);
            check("bp_out_valid", int'(bus.out_valid), 1);
            check("bp_prime_cnt", int'(bus.prime_cnt), 4);
            check("bp_max_run", int'(bus.max_run), 2);
            check("bp_last_prime", int'(bus.last_prime), 7);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("turnaround_in_ready", int'(bus.in_ready), 1);
        check("turnaround_out_valid", int'(bus.out_valid), 0);

        // bubbles, including a long gap inside the 2,3 run
        sb.push_back('{4'd4, 4'd2, 3'd7, 1'b0});
        sweep(1'b0, 1'b1);
        drain();

        // partial frame dropped by reset
        for (int i = 0; i < 5; i++) send(4, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", int'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_out_valid", int'(bus.out_valid), 0);
        sb.push_back('{4'd8, 4'd8, 3'd7, 1'b0});
        for (int i = 0; i < 8; i++) send(7, 1'b1);
        drain();

        // no primes at all
        sb.push_back('{4'd0, 4'd0, 3'd0, 1'b0});
        for (int i = 0; i < 8; i++) send(0, 1'b0);
        drain();

        begin
            int guard;
            guard = 0;
            while (sb.size() != 0 && guard < 100) begin
                @(posedge clk);
                guard++;
            end
            check("reports_outstanding", sb.size(), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
